// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if: bundles the host request, output byte stream and byte-engine signals of spi_flash_reader.
//   master: reader side (drives O_* outputs, samples I_* inputs)
//   slave : environment side (host, data consumer and SPI byte engine)
interface spi_flash_reader_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int LEN_WIDTH  = 16
);
  logic                  I_start;
  logic [ADDR_WIDTH-1:0] I_addr;
  logic [LEN_WIDTH-1:0]  I_count;
  logic                  O_busy;
  logic                  O_done;
  logic [7:0]            O_data;
  logic                  O_data_valid;
  logic                  I_data_ready;
  logic                  O_spi_cs;
  logic [7:0]            O_tx_data;
  logic                  O_tx_start;
  logic                  I_tx_busy;
  logic [7:0]            I_rx_data;
  modport master (
    input  I_start, I_addr, I_count, I_data_ready, I_tx_busy, I_rx_data,
    output O_busy, O_done, O_data, O_data_valid, O_spi_cs, O_tx_data, O_tx_start
  );
  modport slave (
    output I_start, I_addr, I_count, I_data_ready, I_tx_busy, I_rx_data,
    input  O_busy, O_done, O_data, O_data_valid, O_spi_cs, O_tx_data, O_tx_start
  );
endinterface

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: turns one (address, count) request into a SPI flash READ driven through a byte engine.
//   I_clk, I_reset (async, active high); bus (spi_flash_reader_if.master): host request I_start/I_addr/I_count,
//   status O_busy/O_done, byte stream O_data/O_data_valid/I_data_ready, chip select O_spi_cs,
//   byte engine O_tx_data/O_tx_start/I_tx_busy/I_rx_data.
//   Define SPI_FLASH_FAST_READ_EN for FAST READ (0x0B plus one discarded dummy byte).
module spi_flash_reader #(
  parameter int ADDR_WIDTH = 24,
  parameter int LEN_WIDTH  = 16,
  parameter int CS_GAP     = 4
) (
  input logic I_clk,
  input logic I_reset,
  spi_flash_reader_if.master bus
);
  localparam int GW = $clog2(CS_GAP + 1);
  typedef enum logic [2:0] {
    IDLE, CMD, ADDR2, ADDR1, ADDR0,
`ifdef SPI_FLASH_FAST_READ_EN
    DUMMY,
`endif
    DATA, GAP
  } state_t;
  typedef enum logic [1:0] {ISSUE, WAITHI, WAITLO, HOLD} phase_t;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
  localparam state_t POST_ADDR = DUMMY;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
  localparam state_t POST_ADDR = DATA;
`endif
  state_t state, state_n;
  phase_t phase, phase_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0] rem;
  logic [GW-1:0] gap_cnt;
  logic [7:0] data;
  logic data_valid, done;
  logic start_ok, byte_done, accept, gap_last;
  // The done cycle already shows O_busy=0, but a new request is only taken the cycle after it.
  assign start_ok  = state == IDLE && bus.I_start && !done;
  assign byte_done = phase == WAITLO && !bus.I_tx_busy;
  assign accept    = data_valid && bus.I_data_ready;
  assign gap_last  = gap_cnt == GW'(CS_GAP - 1);
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state      <= IDLE;
      phase      <= ISSUE;
      addr_q     <= '0;
      rem        <= '0;
      gap_cnt    <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      done    <= (start_ok && bus.I_count == '0) || (state == GAP && gap_last);
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      if (start_ok) begin
        addr_q <= bus.I_addr;
        rem    <= bus.I_count;
      end
      if (state == DATA && byte_done) begin
        data       <= bus.I_rx_data;
        data_valid <= 1'b1;
        rem        <= rem - 1'b1;
      end else if (accept) data_valid <= 1'b0;
    end
  end
  always_comb begin
    state_n = state;
    phase_n = phase;
    case (state)
      IDLE: if (start_ok && bus.I_count != '0) begin
        state_n = CMD;
        phase_n = ISSUE;
      end
      GAP: if (gap_last) state_n = IDLE;
      default:
        case (phase)
          ISSUE:  phase_n = WAITHI;
          WAITHI: phase_n = bus.I_tx_busy ? WAITLO : WAITHI;
          WAITLO: if (!bus.I_tx_busy) begin
            phase_n = state == DATA ? HOLD : ISSUE;
            state_n = state == CMD   ? ADDR2 :
                      state == ADDR2 ? ADDR1 :
                      state == ADDR1 ? ADDR0 :
                      state == ADDR0 ? POST_ADDR :
                      DATA;
          end
          HOLD: if (accept) begin
            // The next data byte is only issued once the held one is taken.
            phase_n = ISSUE;
            state_n = rem == '0 ? GAP : DATA;
          end
        endcase
    endcase
  end
  assign bus.O_busy       = state != IDLE;
  assign bus.O_done       = done;
  assign bus.O_data       = data;
  assign bus.O_data_valid = data_valid;
  assign bus.O_spi_cs     = state == IDLE || state == GAP;
  assign bus.O_tx_start   = state != IDLE && state != GAP && phase == ISSUE;
  assign bus.O_tx_data    = state == CMD   ? CMD_BYTE :
                            state == ADDR2 ? addr_q[23:16] :
                            state == ADDR1 ? addr_q[15:8] :
                            state == ADDR0 ? addr_q[7:0] :
                            8'h00;
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed bench for spi_flash_reader with a behavioural byte engine and flash responder.
module tb_spi_flash_reader;
  localparam int CS_GAP = 4;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam int HDR = 5;
  localparam logic [7:0] CMDB = 8'h0B;
`else
  localparam int HDR = 4;
  localparam logic [7:0] CMDB = 8'h03;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_flash_reader_if #(.ADDR_WIDTH(24), .LEN_WIDTH(16)) ifc ();
  spi_flash_reader #(.ADDR_WIDTH(24), .LEN_WIDTH(16), .CS_GAP(CS_GAP)) dut (
    .I_clk(clk),
    .I_reset(rst),
    .bus(ifc)
  );
  int vectors = 0, miscompares = 0;
  logic [7:0] resp [8];
  logic [7:0] mosi [$];
  logic [7:0] rxq [$];
  logic eng_busy = 1'b0;
  logic [7:0] eng_rx = 8'h00, eng_tx = 8'h00;
  int eng_cnt = 0, eng_idx = 0;
  assign ifc.I_tx_busy = eng_busy;
  assign ifc.I_rx_data = eng_rx;
  // Byte engine: busy the cycle after the strobe, latches the TX byte mid-shift, returns the flash byte when idle.
  always @(posedge clk) begin
    if (ifc.O_spi_cs) eng_idx <= 0;
    if (ifc.O_tx_start) begin
      eng_busy <= 1'b1;
      eng_cnt  <= 6;
    end else if (eng_busy) begin
      if (eng_cnt == 3) eng_tx <= ifc.O_tx_data;
      if (eng_cnt == 0) begin
        eng_busy <= 1'b0;
        eng_rx   <= eng_idx < HDR ? 8'hEE : resp[(eng_idx - HDR) % 8];
        if (!ifc.O_spi_cs) begin
          mosi.push_back(eng_tx);
          eng_idx <= eng_idx + 1;
        end
      end else eng_cnt <= eng_cnt - 1;
    end
  end
  bit stall_mode = 1'b0;
  int wait_n = 0;
  always @(posedge clk) begin
    #1;
    if (!stall_mode) ifc.I_data_ready = 1'b1;
    else if (ifc.O_data_valid) begin
      wait_n++;
      ifc.I_data_ready = wait_n > 20;
    end else begin
      wait_n = 0;
      ifc.I_data_ready = 1'b0;
    end
  end
  int cyc = 0, cs_falls = 0, cs_rise_cyc = 0, done_cyc = 0, tx_starts = 0, viol = 0, hold = 0, hold_max = 0;
  bit done_seen = 1'b0;
  logic prev_cs = 1'b1, pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;
  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !ifc.O_spi_cs) cs_falls++;
    if (!prev_cs && ifc.O_spi_cs) cs_rise_cyc = cyc;
    prev_cs = ifc.O_spi_cs;
    if (ifc.O_done) begin
      done_seen = 1'b1;
      done_cyc = cyc;
    end
    if (ifc.O_tx_start) tx_starts++;
    if (ifc.O_tx_start && ifc.O_data_valid) viol++;
    if (pv && !pr && (!ifc.O_data_valid || ifc.O_data !== pd)) viol++;
    if (ifc.O_data_valid && ifc.I_data_ready === 1'b1) rxq.push_back(ifc.O_data);
    hold = (ifc.O_data_valid && ifc.I_data_ready === 1'b0) ? hold + 1 : 0;
    if (hold > hold_max) hold_max = hold;
    pv = ifc.O_data_valid;
    pr = ifc.I_data_ready;
    pd = ifc.O_data;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulse_start(input logic [23:0] a, input logic [15:0] n);
    @(posedge clk); #1;
    ifc.I_start = 1'b1;
    ifc.I_addr  = a;
    ifc.I_count = n;
    @(posedge clk); #1;
    ifc.I_start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_seen && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, " done"}, 32'(done_seen), 1);
  endtask
  task automatic run_txn(input logic [23:0] a, input int n, input string tag, input bit intrude);
    logic [7:0] exp [$];
    exp = {CMDB, a[23:16], a[15:8], a[7:0]};
`ifdef SPI_FLASH_FAST_READ_EN
    exp.push_back(8'h00);
`endif
    for (int i = 0; i < n; i++) exp.push_back(8'h00);
    mosi.delete();
    rxq.delete();
    done_seen = 1'b0;
    cs_falls = 0;
    pulse_start(a, 16'(n));
    if (intrude) begin
      repeat (8) @(posedge clk);
      pulse_start(24'hABCDEF, 16'd5);
    end
    wait_done(tag);
    chk($sformatf("%s mosi count", tag), mosi.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s mosi%0d", tag, i), i < mosi.size() ? 32'(mosi[i]) : 32'hDEAD, 32'(exp[i]));
    chk($sformatf("%s data count", tag), rxq.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s data%0d", tag, i), i < rxq.size() ? 32'(rxq[i]) : 32'hDEAD, 32'(resp[i]));
    chk($sformatf("%s cs falls", tag), cs_falls, 1);
    chk($sformatf("%s gap", tag), done_cyc - cs_rise_cyc, CS_GAP);
    @(negedge clk);
    chk($sformatf("%s idle busy", tag), 32'(ifc.O_busy), 0);
    chk($sformatf("%s idle cs", tag), 32'(ifc.O_spi_cs), 1);
  endtask
  initial begin
    int n, t0;
    ifc.I_start = 1'b0;
    ifc.I_addr  = '0;
    ifc.I_count = '0;
    resp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    repeat (2) @(negedge clk);
    chk("rst cs", 32'(ifc.O_spi_cs), 1);
    chk("rst busy", 32'(ifc.O_busy), 0);
    chk("rst done", 32'(ifc.O_done), 0);
    chk("rst valid", 32'(ifc.O_data_valid), 0);
    chk("rst tx_start", 32'(ifc.O_tx_start), 0);
    chk("rst tx_data", 32'(ifc.O_tx_data), 0);
    chk("rst data", 32'(ifc.O_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post rst cs", 32'(ifc.O_spi_cs), 1);
    chk("post rst busy", 32'(ifc.O_busy), 0);
    resp = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(24'h012345, 4, "basic", 1'b0);
    done_seen = 1'b0;
    cs_falls = 0;
    t0 = tx_starts;
    @(posedge clk); #1;
    ifc.I_start = 1'b1;
    ifc.I_addr  = 24'h777777;
    ifc.I_count = 16'd0;
    @(negedge clk);
    chk("zero done early", 32'(ifc.O_done), 0);
    @(posedge clk); #1;
    ifc.I_start = 1'b0;
    @(negedge clk);
    chk("zero done pulse", 32'(ifc.O_done), 1);
    chk("zero busy", 32'(ifc.O_busy), 0);
    @(negedge clk);
    chk("zero done end", 32'(ifc.O_done), 0);
    repeat (5) @(negedge clk);
    chk("zero cs", cs_falls, 0);
    chk("zero tx_start", tx_starts - t0, 0);
    resp = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    stall_mode = 1'b1;
    viol = 0;
    hold_max = 0;
    run_txn(24'h00ABCD, 3, "stall", 1'b0);
    stall_mode = 1'b0;
    chk("stall hold violations", viol, 0);
    chk("stall held 20", 32'(hold_max >= 20), 1);
    resp = '{8'h05, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(24'h000200, 2, "intrude", 1'b1);
    repeat (20) @(negedge clk);
    chk("intrude no restart", cs_falls, 1);
    chk("intrude idle", 32'(ifc.O_busy), 0);
    resp = '{8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    done_seen = 1'b0;
    t0 = tx_starts;
    pulse_start(24'h0A0B0C, 16'd2);
    n = 0;
    while (tx_starts < t0 + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst reached addr1", tx_starts - t0, 3);
    chk("rst tx_data addr1", 32'(ifc.O_tx_data), 32'h0B);
    @(posedge clk); #2;
    chk("rst cs before", 32'(ifc.O_spi_cs), 0);
    rst = 1'b1;
    #1;
    chk("rst cs immediate", 32'(ifc.O_spi_cs), 1);
    chk("rst busy immediate", 32'(ifc.O_busy), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst no done", 32'(done_seen), 0);
    resp = '{8'h9A, 8'hBC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(24'h000010, 2, "post rst", 1'b0);
    resp = '{8'hD1, 8'hE2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(24'h000100, 2, "addr100", 1'b0);
    chk("global violations", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
